sum_7seg_scan: RTL



---
 rtl/sum_7seg_scan.sv | 102 ++++++++++
 1 files changed

// File: rtl/sum_7seg_scan.sv
// Captures the 5-bit adder result and scans it as two decimal digits onto a
// common-anode 7-segment display, with a dark gap cycle at each digit switch.
module sum_7seg_scan #(
    parameter int SCAN_DIV = 50000,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [3:0] SUM,
    input  logic       C_OUT,
    input  logic       LOAD,
    output logic [4:0] VALUE,
    output logic [1:0] AN,
    output logic [6:0] SEG
);
    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);

    logic [CW-1:0] cnt;
    logic          dig;
    logic          gap;
    logic          tc;
    logic [1:0]    tens;
    logic [3:0]    ones;

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 7'h40;
            4'd1:    seg_code = 7'h79;
            4'd2:    seg_code = 7'h24;
            4'd3:    seg_code = 7'h30;
            4'd4:    seg_code = 7'h19;
            4'd5:    seg_code = 7'h12;
            4'd6:    seg_code = 7'h02;
            4'd7:    seg_code = 7'h78;
            4'd8:    seg_code = 7'h00;
            4'd9:    seg_code = 7'h10;
            default: seg_code = 7'h7F;
        endcase
    endfunction

    // Value never exceeds 31, so a compare ladder replaces a real divider.
    always_comb begin
        tens = 2'd0;
        ones = VALUE[3:0];
        if (VALUE >= 5'd30) begin
            tens = 2'd3;
            ones = 4'(VALUE - 5'd30);
        end else if (VALUE >= 5'd20) begin
            tens = 2'd2;
            ones = 4'(VALUE - 5'd20);
        end else if (VALUE >= 5'd10) begin
            tens = 2'd1;
            ones = 4'(VALUE - 5'd10);
        end
    end

    assign tc = (cnt == CNT_MAX);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            VALUE <= '0;
        end else if (LOAD) begin
            VALUE <= {C_OUT, SUM};
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt <= '0;
            dig <= 1'b0;
            gap <= 1'b0;
        end else if (tc) begin
            cnt <= '0;
            dig <= ~dig;
            gap <= 1'b1;
        end else begin
            cnt <= cnt + CW'(1);
            gap <= 1'b0;
        end
    end

    // Gap takes priority so the outgoing digit never bleeds into the next slot.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            AN  <= 2'b11;
            SEG <= 7'h7F;
        end else if (gap) begin
            AN  <= 2'b11;
            SEG <= 7'h7F;
        end else if (dig && BLANK_LZ && tens == 2'd0) begin
            AN  <= 2'b11;
            SEG <= 7'h7F;
        end else if (!dig) begin
            AN  <= 2'b10;
            SEG <= seg_code(ones);
        end else begin
            AN  <= 2'b01;
            SEG <= seg_code({2'b00, tens});
        end
    end
endmodule
